// File: rtl/result_serializer.sv
// Captures one decode result on start and streams it out as a byte message:
// header, iteration count, 4-byte cycle count, then the correction vector (MSB first).
module result_serializer #(
  parameter int unsigned CORRECTION_WIDTH        = 12,
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
  parameter logic [7:0]  RESULT_HEADER           = 8'hA5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_count,
  input  logic [31:0]                        cycle_count,
  input  logic [CORRECTION_WIDTH-1:0]        corrections,
  output logic [7:0]                         output_data,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned NC        = (CORRECTION_WIDTH + 7) / 8;
  localparam int unsigned CORR_BITS = NC * 8;
  localparam int unsigned IDX_MAX   = (NC > 4) ? NC : 4;
  localparam int unsigned IDX_W     = $clog2(IDX_MAX);
  localparam logic [IDX_W-1:0] CYC_LAST  = IDX_W'(3);
  localparam logic [IDX_W-1:0] CORR_LAST = IDX_W'(NC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ITER,
    S_CYCLE,
    S_CORR
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           iter_q, iter_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [CORR_BITS-1:0] corr_q, corr_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 xfer;

  // Byte to present for a given state/index, from the captured result.
  function automatic logic [7:0] pick_byte(input state_e st, input logic [IDX_W-1:0] idx,
                                           input logic [7:0] it, input logic [31:0] cy,
                                           input logic [CORR_BITS-1:0] co);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_HEADER: b = RESULT_HEADER;
      S_ITER:   b = it;
      S_CYCLE:  b = 8'(cy >> (8 * (3 - 32'(idx))));
      S_CORR:   b = 8'(co >> (8 * (NC - 1 - 32'(idx))));
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    cyc_d   = cyc_q;
    corr_d  = corr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    xfer    = valid_q && output_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = 8'(iteration_count);
          cyc_d   = cycle_count;
          corr_d  = CORR_BITS'(corrections);
          state_d = S_HEADER;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = RESULT_HEADER;
        end
      end
      S_HEADER: if (xfer) state_d = S_ITER;
      S_ITER: begin
        if (xfer) begin
          state_d = S_CYCLE;
          idx_d   = '0;
        end
      end
      S_CYCLE: begin
        if (xfer) begin
          if (idx_q == CYC_LAST) begin
            state_d = S_CORR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_CORR: begin
        if (xfer) begin
          if (idx_q == CORR_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    // Load the following byte only on a handshake so stalls hold the data steady.
    if (xfer && (state_d != S_IDLE)) begin
      data_d = pick_byte(state_d, idx_d, iter_q, cyc_q, corr_q);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      iter_q  <= '0;
      cyc_q   <= '0;
      corr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      cyc_q   <= cyc_d;
      corr_q  <= corr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign output_data  = data_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: default build plus 8-bit and 1-bit correction builds.
module tb_result_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_m, start_w, ready_m;
  logic        ready_w = 1'b1;
  logic [7:0]  iter_i;
  logic [31:0] cyc_i;
  logic [11:0] corr_m;
  logic [7:0]  corr_8;
  logic        corr_1;

  logic [7:0] data_m, data_8, data_1;
  logic       valid_m, busy_m, done_m;
  logic       valid_8, busy_8, done_8;
  logic       valid_1, busy_1, done_1;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [8];
  logic [7:0] exp8  [7];
  logic [7:0] exp1  [7];

  result_serializer u_dut (
    .clk(clk), .reset(rst_n), .start(start_m), .iteration_count(iter_i),
    .cycle_count(cyc_i), .corrections(corr_m), .output_data(data_m),
    .output_valid(valid_m), .output_ready(ready_m), .busy(busy_m), .done(done_m)
  );

  result_serializer #(.CORRECTION_WIDTH(8)) u_w8 (
    .clk(clk), .reset(rst_n), .start(start_w), .iteration_count(iter_i),
    .cycle_count(cyc_i), .corrections(corr_8), .output_data(data_8),
    .output_valid(valid_8), .output_ready(ready_w), .busy(busy_8), .done(done_8)
  );

  result_serializer #(.CORRECTION_WIDTH(1)) u_w1 (
    .clk(clk), .reset(rst_n), .start(start_w), .iteration_count(iter_i),
    .cycle_count(cyc_i), .corrections(corr_1), .output_data(data_1),
    .output_valid(valid_1), .output_ready(ready_w), .busy(busy_1), .done(done_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the start edge; ends in the cycle that should carry done.
  task automatic run_msg(input string name, input bit bp, input int inj_cyc, input bit inj_last);
    int         got;
    int         cyc;
    bit         stalled;
    logic [7:0] prev;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = 8'h00;
    while (got < 8 && cyc < 100) begin
      ready_m = !bp || (cyc % 3 == 0);
      start_m = 1'b0;
      if (cyc == inj_cyc || (inj_last && got == 7 && ready_m)) begin
        start_m = 1'b1;
        iter_i  = 8'h77;
        cyc_i   = 32'hFFFF_FFFF;
        corr_m  = 12'h555;
      end
      if (stalled) chk({name, "_stall_hold"}, 32'(data_m), 32'(prev));
      chk({name, "_valid"}, 32'(valid_m), 1);
      chk({name, "_busy"}, 32'(busy_m), 1);
      chk({name, "_no_early_done"}, 32'(done_m), 0);
      if (ready_m) begin
        chk($sformatf("%s_byte%0d", name, got), 32'(data_m), 32'(exp_q[got]));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev    = data_m;
      end
      step();
      cyc++;
    end
    start_m = 1'b0;
    ready_m = 1'b1;
    chk({name, "_length"}, 32'(got), 8);
    chk({name, "_done"}, 32'(done_m), 1);
    chk({name, "_valid_low_at_done"}, 32'(valid_m), 0);
  endtask

  initial begin
    rst_n   = 1'b1;
    start_m = 1'b0;
    start_w = 1'b0;
    ready_m = 1'b1;
    iter_i  = 8'h00;
    cyc_i   = 32'h0;
    corr_m  = 12'h0;
    corr_8  = 8'h00;
    corr_1  = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_m), 0);
    chk("rst_data", 32'(data_m), 0);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_done", 32'(done_m), 0);
    chk("rst_w8_busy", 32'(busy_8), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(valid_m), 0);
    chk("idle_busy", 32'(busy_m), 0);

    // Basic message with output_ready held high.
    iter_i = 8'd5; cyc_i = 32'h0000_0123; corr_m = 12'hABC;
    exp_q = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h01, 8'h23, 8'h0A, 8'hBC};
    start_m = 1'b1;
    step();
    run_msg("basic", 1'b0, -1, 1'b0);
    step();
    chk("basic_done_one_cycle", 32'(done_m), 0);

    // Same message under 1,0,0 backpressure.
    start_m = 1'b1;
    step();
    run_msg("bp", 1'b1, -1, 1'b0);
    step();

    // Starts during CYCLE and on the final handshake are ignored.
    iter_i = 8'd5; cyc_i = 32'h0000_0123; corr_m = 12'hABC;
    start_m = 1'b1;
    step();
    run_msg("ign", 1'b0, 2, 1'b1);
    chk("ign_busy_at_done", 32'(busy_m), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign_no_second_valid", 32'(valid_m), 0);
      chk("ign_no_second_busy", 32'(busy_m), 0);
    end

    // Back-to-back: second start issued in the done cycle.
    iter_i = 8'h0C; cyc_i = 32'h89AB_CDEF; corr_m = 12'h123;
    exp_q = '{8'hA5, 8'h0C, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23};
    start_m = 1'b1;
    step();
    run_msg("b2b1", 1'b0, -1, 1'b0);
    iter_i = 8'hFF; cyc_i = 32'h0001_0203; corr_m = 12'hFFF;
    exp_q = '{8'hA5, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'hFF};
    start_m = 1'b1;
    step();
    run_msg("b2b2", 1'b0, -1, 1'b0);
    step();

    // Reset asserted while in CORR aborts the message.
    iter_i = 8'd2; cyc_i = 32'h0000_0010; corr_m = 12'hABC;
    start_m = 1'b1;
    step();
    start_m = 1'b0;
    repeat (6) step();
    chk("mid_in_corr_data", 32'(data_m), 32'h0A);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_m), 0);
    chk("mid_rst_busy", 32'(busy_m), 0);
    chk("mid_rst_data", 32'(data_m), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 32'(valid_m), 0);
      chk("post_rst_busy", 32'(busy_m), 0);
    end
    iter_i = 8'd1; cyc_i = 32'h0000_0001; corr_m = 12'h800;
    exp_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
    start_m = 1'b1;
    step();
    run_msg("post_rst", 1'b0, -1, 1'b0);
    step();

    // Width corners: 8-bit and 1-bit correction vectors.
    iter_i = 8'd3; cyc_i = 32'hDEAD_BEEF; corr_8 = 8'hFF; corr_1 = 1'b1;
    exp8 = '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
    exp1 = '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("w8_byte%0d", k), 32'(data_8), 32'(exp8[k]));
      chk($sformatf("w1_byte%0d", k), 32'(data_1), 32'(exp1[k]));
      chk("w8_valid", 32'(valid_8), 1);
      chk("w1_valid", 32'(valid_1), 1);
      step();
    end
    chk("w8_done", 32'(done_8), 1);
    chk("w1_done", 32'(done_1), 1);
    chk("w8_valid_end", 32'(valid_8), 0);
    chk("w1_busy_end", 32'(busy_1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 The block SHALL have parameter CORRECTION_WIDTH, default 12: number of correction bits per decode result, valid range 1..1024.
REQ-002 The block SHALL have parameter ITERATION_COUNTER_WIDTH, default 8: iteration count width, valid range 1..8.
REQ-003 The block SHALL have parameter RESULT_HEADER, default 8'hA5: first byte of every result message.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle capture pulse issued by the stage controller in STAGE_RESULT_VALID.
REQ-007 The block SHALL have port iteration_count, input, ITERATION_COUNTER_WIDTH bits: grow iterations of the finished decode.
REQ-008 The block SHALL have port cycle_count, input, 32 bits: decode cycle count.
REQ-009 The block SHALL have port corrections, input, CORRECTION_WIDTH bits: correction vector from the PE array.
REQ-010 The block SHALL have port output_data, output, 8 bits: outgoing byte.
REQ-011 The block SHALL have port output_valid, output, 1 bit: output_data holds a valid byte.
REQ-012 The block SHALL have port output_ready, input, 1 bit: downstream accepts a byte.
REQ-013 The block SHALL have port busy, output, 1 bit: a message is being captured or sent.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last byte of a message is accepted.

Function
REQ-015 States SHALL be IDLE, HEADER, ITER, CYCLE, CORR; busy SHALL be high in every state except IDLE.
REQ-016 In IDLE, start=1 SHALL capture iteration_count, cycle_count and corrections into internal registers on that edge and SHALL move to HEADER.
REQ-017 Latency: output_valid SHALL be high in the cycle after start, with output_data = RESULT_HEADER.
REQ-018 A byte SHALL be transferred only on a cycle with output_valid=1 and output_ready=1; the state or byte index SHALL advance on that edge only.
REQ-019 While output_valid=1 and output_ready=0, output_data SHALL hold its value and output_valid SHALL stay high.
REQ-020 Message byte order: RESULT_HEADER; iteration_count zero-extended to 8 bits; cycle_count as 4 bytes, most significant byte first; corrections as NC = ceil(CORRECTION_WIDTH/8) bytes, most significant byte first.
REQ-021 In the corrections field, the unused upper bits of the first byte SHALL be 0.
REQ-022 Total message length SHALL be 6 + NC bytes; the byte index counter SHALL be sized for NC and SHALL NOT wrap within a message.
REQ-023 Transitions SHALL be: HEADER to ITER to CYCLE after 1 byte each; CYCLE to CORR after 4 bytes; CORR to IDLE after NC bytes.
REQ-024 done SHALL pulse high for exactly one cycle, namely the cycle after the final byte handshake, which is also the first cycle back in IDLE.
REQ-025 start while busy=1 SHALL be ignored, including in the cycle of the final handshake; captured data SHALL stay unchanged.
REQ-026 start in the IDLE cycle that carries the done pulse SHALL be accepted normally.
REQ-027 Input ports SHALL be sampled only at the start capture edge; later changes SHALL NOT affect the message in flight.
REQ-028 All outputs SHALL be driven from registers.

Reset
REQ-029 While reset=0, the block SHALL force state=IDLE, output_valid=0, output_data=8'h00, busy=0, done=0, clear the byte counters and clear the captured registers, immediately and without waiting for clk.
REQ-030 Reset asserted mid-message SHALL abort the message; after release the block SHALL sit in IDLE with output_valid=0 until the next start, and SHALL NOT resume or emit any partial remainder.

Verification
REQ-031 Defaults, output_ready held 1: start with iteration_count=5, cycle_count=32'h00000123, corrections=12'hABC -> output bytes A5,05,00,00,01,23,0A,BC on 8 consecutive cycles; done pulses on the 9th cycle after start.
REQ-032 Backpressure: same stimulus, output_ready toggling 1,0,0,1,... -> same 8-byte sequence; output_data stable during every stall; no byte duplicated or dropped.
REQ-033 Ignored start: start pulsed during the CYCLE state with different inputs -> the message in flight is unchanged; no second message follows.
REQ-034 Back-to-back: start asserted in the done cycle -> the second message's header is valid in the next cycle; both messages are complete and correct.
REQ-035 Reset mid-operation: reset driven low during CORR -> output_valid=0 and busy=0 asynchronously; after release and a new start, one complete message is emitted.
REQ-036 Width corner: CORRECTION_WIDTH=8, corrections=8'hFF -> message is A5,it,c3,c2,c1,c0,FF (7 bytes); CORRECTION_WIDTH=1, corrections=1 -> last byte is 01.
